u712_cycle_arb: RTL

U712_CYCLE_ARB -- requirements
Module: U712_CYCLE_ARB

---
 rtl/u712_cycle_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/u712_cycle_arb.sv
// Chip-RAM cycle arbiter sharing one SDRAM sequencer between DMA, CPU and refresh.
// Build option: define REFRESH_POSTPONE_EN to let CPU cycles postpone refresh up to REF_FORCE_LVL.
module u712_cycle_arb #(
  parameter int unsigned REF_DEBT_MAX  = 8,
  parameter int unsigned REF_FORCE_LVL = 6,
  parameter int unsigned WDOG_CYCLES   = 31
) (
  input  logic       CLK80,
  input  logic       RESET,
  input  logic       DMA_REQ,
  input  logic       CPU_REQ,
  input  logic       DBR,
  input  logic       REF_TICK,
  input  logic       SEQ_DONE,
  output logic       SEQ_START,
  output logic [1:0] GNT,
  output logic       CPU_ACK,
  output logic [3:0] REF_DEBT,
  output logic [2:0] ERR
);

  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntCpu  = 2'b01;
  localparam logic [1:0] GntDma  = 2'b10;
  localparam logic [1:0] GntRef  = 2'b11;

  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);
  localparam logic [3:0] DebtMax = 4'(REF_DEBT_MAX);

`ifdef REFRESH_POSTPONE_EN
  localparam logic [3:0] ForceLvl = 4'(REF_FORCE_LVL);
`else
  // Without postponement any owed refresh outranks the CPU, so the threshold collapses to 1.
  localparam logic [3:0] ForceLvl = (REF_FORCE_LVL != 0) ? 4'd1 : 4'd1;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StRecover} state_e;

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             seq_start_q;
  logic [3:0]       debt_q;
  logic [2:0]       err_q;
  logic             dma_pend_q;
  logic [WdogW-1:0] wdog_q;

  logic       dma_pend;
  logic       cpu_ok;
  logic       busy_done;
  logic       ref_done;
  logic [1:0] winner;

  // A DMA pulse arriving in the IDLE cycle itself is already eligible.
  assign dma_pend  = dma_pend_q | DMA_REQ;
  assign cpu_ok    = CPU_REQ & ~DBR;
  assign busy_done = (state_q == StBusy) & SEQ_DONE;
  assign ref_done  = busy_done & (gnt_q == GntRef);

  always_comb begin
    winner = GntNone;
    if (dma_pend) begin
      winner = GntDma;
    end else if (debt_q >= ForceLvl) begin
      winner = GntRef;
    end else if (cpu_ok) begin
      winner = GntCpu;
    end else if (debt_q != 4'd0) begin
      winner = GntRef;
    end
  end

  always_ff @(negedge CLK80) begin
    if (RESET) begin
      state_q     <= StIdle;
      gnt_q       <= GntNone;
      seq_start_q <= 1'b0;
      debt_q      <= 4'd0;
      err_q       <= 3'b000;
      dma_pend_q  <= 1'b0;
      wdog_q      <= '0;
    end else begin
      seq_start_q <= 1'b0;

      // A tick and a refresh completion in the same cycle cancel out.
      if (REF_TICK && !ref_done) begin
        if (debt_q == DebtMax) begin
          err_q[0] <= 1'b1;
        end else begin
          debt_q <= debt_q + 4'd1;
        end
      end else if (ref_done && !REF_TICK) begin
        debt_q <= debt_q - 4'd1;
      end

      if (DMA_REQ && dma_pend_q) begin
        err_q[1] <= 1'b1;
      end
      if (state_q == StIdle && winner == GntDma) begin
        dma_pend_q <= 1'b0;
      end else if (DMA_REQ) begin
        dma_pend_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (winner != GntNone) begin
            state_q     <= StStart;
            seq_start_q <= 1'b1;
            gnt_q       <= winner;
          end
        end
        StStart: begin
          state_q <= StBusy;
          wdog_q  <= '0;
        end
        StBusy: begin
          if (SEQ_DONE) begin
            state_q <= StRecover;
            gnt_q   <= GntNone;
          end else if (wdog_q == WdogLast) begin
            // Abort: debt and CPU request are left untouched so the cycle is retried.
            state_q  <= StRecover;
            gnt_q    <= GntNone;
            err_q[2] <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
        end
        StRecover: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign SEQ_START = seq_start_q;
  assign GNT       = gnt_q;
  assign CPU_ACK   = busy_done & (gnt_q == GntCpu) & ~RESET;
  assign REF_DEBT  = debt_q;
  assign ERR       = err_q;

endmodule
